// File: rtl/modex_sequencer.sv
// Self-timed run controller in front of the MODEX processor: issues one start per word,
// waits for the result with a per-word timeout, and writes it to the result RAM.
//   state   | meaning
//   S_IDLE  | waiting for a rising edge on go
//   S_ISSUE | mx_start pulse for the current word
//   S_WAIT  | waiting for mx_done, timer running
//   S_WRITE | wr_en pulse, advance to the next word
//   S_DONE  | run complete, held until go is low
//   S_ERROR | word timed out, held until go is low
module modex_sequencer #(
  parameter int ADDR      = 10,
  parameter int ARQ       = 16,
  parameter int NUM_WORDS = 1024,
  parameter int TIMEOUT   = 4095
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            err_timeout,
  output logic [ADDR-1:0] mx_addr,
  output logic            mx_start,
  input  logic            mx_done,
  input  logic [ARQ-1:0]  mx_result,
  output logic            wr_en,
  output logic [ADDR-1:0] wr_addr,
  output logic [ARQ-1:0]  wr_data,
  output logic [ADDR:0]   words_written
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLOAD     = TW'(TIMEOUT - 1);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic          go_q;
  logic [TW-1:0] wait_cnt;

  // Timer counts down from TIMEOUT-1; the WAIT cycle that sees zero is the last one allowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      go_q          <= 1'b0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      mx_addr       <= '0;
      mx_start      <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      words_written <= '0;
    end else begin
      go_q     <= go;
      mx_start <= 1'b0;
      wr_en    <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        done        <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go && !go_q) begin
              mx_addr       <= '0;
              words_written <= '0;
              mx_start      <= 1'b1;
              busy          <= 1'b1;
              state         <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            wait_cnt <= TLOAD;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (mx_done) begin
              wr_data       <= mx_result;
              wr_addr       <= mx_addr;
              wr_en         <= 1'b1;
              words_written <= words_written + 1'b1;
              state         <= S_WRITE;
            end else if (wait_cnt == '0) begin
              busy        <= 1'b0;
              err_timeout <= 1'b1;
              state       <= S_ERROR;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          S_WRITE: begin
            if (mx_addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              mx_addr  <= mx_addr + 1'b1;
              mx_start <= 1'b1;
              state    <= S_ISSUE;
            end
          end
          S_DONE: begin
            if (!go) begin
              done  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_ERROR: begin
            if (!go) begin
              err_timeout <= 1'b0;
              state       <= S_IDLE;
            end
          end
          default: begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modex_sequencer.sv
// Randomized bench for modex_sequencer: a cycle-arithmetic run model fills a scoreboard,
// a processor responder answers mx_start, and a monitor checks writes and run endings.
module tb_modex_sequencer;
  localparam int ADDR = 4;
  localparam int ARQ  = 16;
  localparam int NW   = 4;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst, go, abort, mx_done;
  logic [ARQ-1:0]  mx_result;
  logic            busy, done, err_timeout, mx_start, wr_en;
  logic [ADDR-1:0] mx_addr, wr_addr;
  logic [ARQ-1:0]  wr_data;
  logic [ADDR:0]   words_written;

  modex_sequencer #(.ADDR(ADDR), .ARQ(ARQ), .NUM_WORDS(NW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .mx_addr(mx_addr), .mx_start(mx_start), .mx_done(mx_done), .mx_result(mx_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .words_written(words_written)
  );

  initial forever #5 clk = ~clk;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int kind; int cyc; int ww; int addr;} end_t;

  wr_t  wq[$];
  end_t eq[$];
  int   sq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_g = 0;
  int ends_seen = 0;
  int lat_a[NW];
  int res_a[NW];
  bit stale_a[NW];

  always @(posedge clk) cyc_g = cyc_g + 1;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  // Run outcome from per-word latencies: a word starting at cycle s with latency k
  // (1..TO) writes at s+k+1 and the next word starts at s+k+2; otherwise ERROR at s+TO+1.
  // Abort sampled at the end of cycle a leaves IDLE visible at a+1.
  // kind: 2 = done, 1 = timeout, 0 = abort.
  function automatic int model(input bit ab_en, input int a, input bit push);
    int t, ww, s, w, e, addr, kind;
    t = 0; ww = 0; e = -1; addr = NW - 1; kind = 2;
    for (int i = 0; i < NW; i++) begin
      s = t;
      if (ab_en && a < s) begin kind = 0; e = a + 1; addr = i - 1; break; end
      if (lat_a[i] >= 1 && lat_a[i] <= TO) begin
        w = s + lat_a[i] + 1;
        if (ab_en && a < w) begin kind = 0; e = a + 1; addr = i; break; end
        if (push) wq.push_back('{i, res_a[i]});
        ww++;
        t = w + 1;
      end else begin
        if (ab_en && a < s + TO + 1) begin kind = 0; e = a + 1; addr = i; break; end
        kind = 1; e = s + TO + 1; addr = i; break;
      end
    end
    if (e < 0) begin
      if (ab_en && a < t) begin kind = 0; e = a + 1; end
      else e = t;
    end
    if (push) eq.push_back('{kind, e, ww, addr});
    return e;
  endfunction

  // Processor stand-in: answers lat_a[addr] cycles after the mx_start cycle (0 = never).
  initial begin
    int cnt, cur;
    cnt = 0; cur = 0;
    mx_done = 1'b0; mx_result = '0;
    forever begin
      @(negedge clk);
      mx_done = 1'b0;
      mx_result = ARQ'($urandom);
      if (!rst && mx_start) begin
        cur = int'(mx_addr);
        cnt = lat_a[cur];
        if (stale_a[cur]) begin mx_done = 1'b1; mx_result = 16'hDEAD; end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin mx_done = 1'b1; mx_result = ARQ'(res_a[cur]); end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT starts a run, writes, or ends a run.
  initial begin
    bit in_run, busy_p, done_p, err_p;
    int rcyc;
    wr_t wx;
    end_t ex;
    in_run = 0; busy_p = 0; done_p = 0; err_p = 0; rcyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mx_start && !in_run) begin
          if (sq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_start: mx_start at cycle %0d, none required", cyc_g);
          end else chk("start_cycle", cyc_g, sq.pop_front());
          in_run = 1; rcyc = 0;
        end else if (in_run) rcyc++;
        if (wr_en) begin
          if (wq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required", wr_addr, wr_data);
          end else begin
            wx = wq.pop_front();
            chk("write_addr", int'(wr_addr), wx.addr);
            chk("write_data", int'(wr_data), wx.data);
          end
        end
        if (in_run && ((done && !done_p) || (err_timeout && !err_p) || (busy_p && !busy))) begin
          if (eq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_end: run ended at %0d, no end required", rcyc);
          end else begin
            ex = eq.pop_front();
            chk("end_kind", int'({done, err_timeout}), ex.kind);
            chk("end_cycle", rcyc, ex.cyc);
            chk("end_words_written", int'(words_written), ex.ww);
            chk("end_mx_addr", int'(mx_addr), ex.addr);
          end
          in_run = 0;
          ends_seen++;
        end
      end
      busy_p = busy; done_p = done; err_p = err_timeout;
    end
  end

  task automatic set_basic();
    for (int i = 0; i < NW; i++) begin
      lat_a[i] = 1; res_a[i] = 16'h00A0 + i; stale_a[i] = 0;
    end
  endtask

  task automatic set_random();
    int p;
    for (int i = 0; i < NW; i++) begin
      p = $urandom_range(0, 19);
      if (p == 0) lat_a[i] = 0;
      else if (p == 1) lat_a[i] = TO + $urandom_range(1, 3);
      else if (p == 2) lat_a[i] = TO;
      else lat_a[i] = $urandom_range(1, 4);
      res_a[i] = int'($urandom_range(0, 16'hFFFF));
      stale_a[i] = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic run_one(input bit ab_en, input int a_fix, input int hold_in, input bit go_level);
    int e_nat, a, g, c, hold, target;
    e_nat = model(1'b0, 0, 1'b0);
    a = (a_fix >= 0) ? a_fix : $urandom_range(0, e_nat - 1);
    hold = go_level ? e_nat + 6 : hold_in;
    void'(model(ab_en, a, 1'b1));
    target = ends_seen + 1;
    @(negedge clk);
    go = 1'b1;
    g = cyc_g;
    sq.push_back(g + 1);
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      abort = ab_en && (c == a + 1);
      if (c == hold) begin
        if (go_level && !ab_en) chk("go_level_done_held", int'({busy, done}), 1);
        go = 1'b0;
      end
      if (ends_seen >= target && c > hold && !abort) break;
      if (c > 500) begin
        n_cmp++; n_bad++;
        $display("FAIL run_end_timeout: ends seen %0d, required %0d", ends_seen, target);
        wq.delete(); eq.delete(); sq.delete();
        break;
      end
    end
    go = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_run", int'({busy, done, err_timeout}), 0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b1; abort = 1'b0;
    set_basic();
    repeat (3) @(negedge clk);
    chk("reset_flags", int'({busy, done, err_timeout, mx_start, wr_en}), 0);
    chk("reset_mx_addr", int'(mx_addr), 0);
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    chk("reset_words_written", int'(words_written), 0);
    rst = 1'b0; go = 1'b0;
    repeat (2) @(negedge clk);

    set_basic();                                 run_one(1'b0, -1, 2, 1'b0);
    set_basic(); lat_a[2] = 0;                   run_one(1'b0, -1, 2, 1'b0);
    set_basic(); lat_a[1] = TO; res_a[1] = 16'hBEEF; run_one(1'b0, -1, 2, 1'b0);
    set_basic(); lat_a[1] = 3; stale_a[1] = 1;   run_one(1'b0, -1, 2, 1'b0);
    set_basic();                                 run_one(1'b1, 4, 2, 1'b0);
    set_basic();                                 run_one(1'b0, -1, 2, 1'b1);
    set_basic();                                 run_one(1'b0, -1, 1, 1'b0);

    for (int r = 0; r < 30; r++) begin
      set_random();
      run_one($urandom_range(0, 3) == 0, -1, $urandom_range(1, 12), $urandom_range(0, 5) == 0);
    end

    chk("scoreboard_drained", wq.size() + eq.size() + sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
